// File: rtl/row_sum3.sv
// Streaming 3-row vertical adder: buffers two rows, emits col-wise sum of rows r-2, r-1, r.
// Latency 1 cycle from accepted byte to po_flag; no backpressure, one output per input from row 2 on.
module row_sum3 #(
    parameter int COL_MAX      = 50,
    parameter int ROW_MAX      = 50,
    parameter int SUM_W        = 8,
    parameter int IDLE_TIMEOUT = 1000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [7:0]       pi_data,
    input  logic             pi_flag,
    output logic [SUM_W-1:0] po_sum,
    output logic             po_flag,
    output logic             frame_done
);

    localparam int CW = (COL_MAX > 1) ? $clog2(COL_MAX) : 1;
    localparam int RW = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [IW-1:0] idle_cnt;

    logic [7:0] buf_a [COL_MAX];
    logic [7:0] buf_b [COL_MAX];

    logic       col_last;
    logic       row_last;
    logic       row_out;
    logic       mid_frame;
    logic       timeout;
    logic [9:0] sum10;

    assign col_last  = (col_cnt == CW'(COL_MAX - 1));
    assign row_last  = (row_cnt == RW'(ROW_MAX - 1));
    assign row_out   = (row_cnt >= RW'(2));
    assign mid_frame = (col_cnt != '0) || (row_cnt != '0);
    assign timeout   = (idle_cnt == IW'(IDLE_TIMEOUT));
    // Buffers are read here in the same cycle they are rewritten below (read-before-write).
    assign sum10     = 10'(buf_a[col_cnt]) + 10'(buf_b[col_cnt]) + 10'(pi_data);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            po_sum     <= '0;
            po_flag    <= 1'b0;
            frame_done <= 1'b0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            idle_cnt   <= '0;
        end else begin
            po_flag    <= 1'b0;
            frame_done <= 1'b0;
            if (pi_flag) begin
                idle_cnt <= '0;
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= row_last ? '0 : row_cnt + RW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
                if (row_out) begin
                    po_sum  <= SUM_W'(sum10);
                    po_flag <= 1'b1;
                end
                frame_done <= col_last && row_last;
            end else if (timeout) begin
                // Stalled mid-frame too long: drop the partial frame and wait for a fresh row 0.
                col_cnt  <= '0;
                row_cnt  <= '0;
                idle_cnt <= '0;
            end else if (mid_frame) begin
                idle_cnt <= idle_cnt + IW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (pi_flag) begin
            if (row_cnt == RW'(0)) begin
                buf_a[col_cnt] <= pi_data;
            end else if (row_cnt == RW'(1)) begin
                buf_b[col_cnt] <= pi_data;
            end else begin
                buf_a[col_cnt] <= buf_b[col_cnt];
                buf_b[col_cnt] <= pi_data;
            end
        end
    end

endmodule

// File: tb/tb_row_sum3.sv
// Directed bench for row_sum3 with a 4x4 frame; a SUM_W=10 twin shares the inputs.
module tb_row_sum3;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [7:0] pi_data = 8'd0;
    logic       pi_flag = 1'b0;
    logic [7:0] po_sum;
    logic       po_flag;
    logic       frame_done;
    logic [9:0] po_sum10;
    logic       po_flag10;
    logic       frame_done10;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int fd_cnt = 0;

    int sum_q[$];
    int sum10_q[$];
    int cyc_q[$];
    int fd_q[$];
    int cap_q[$];

    row_sum3 #(.COL_MAX(4), .ROW_MAX(4), .SUM_W(8), .IDLE_TIMEOUT(20)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
        .po_sum(po_sum), .po_flag(po_flag), .frame_done(frame_done)
    );

    row_sum3 #(.COL_MAX(4), .ROW_MAX(4), .SUM_W(10), .IDLE_TIMEOUT(20)) dut10 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
        .po_sum(po_sum10), .po_flag(po_flag10), .frame_done(frame_done10)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (po_flag) begin
            sum_q.push_back(int'(po_sum));
            sum10_q.push_back(int'(po_sum10));
            cyc_q.push_back(cyc);
            fd_q.push_back(int'(frame_done));
        end
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic drive(input logic f, input logic [7:0] d);
        pi_flag = f;
        pi_data = d;
        @(posedge sys_clk);
        #1;
        if (f) cap_q.push_back(cyc);
        pi_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'd0);
    endtask

    task automatic send_seq(input int first, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 8'(first + i));
            idle(gap);
        end
    endtask

    task automatic clear_q();
        sum_q.delete();
        sum10_q.delete();
        cyc_q.delete();
        fd_q.delete();
        cap_q.delete();
        fd_cnt = 0;
    endtask

    // One 4x4 frame of consecutive values starting at 'first', whose bytes begin at cap_q[off].
    task automatic check_frame(input string tag, input int first, input int off, input int nfd);
        int v;
        chk({tag, "_count"}, sum_q.size(), 8);
        chk({tag, "_fd_count"}, fd_cnt, nfd);
        for (int j = 0; j < 8 && j < sum_q.size(); j++) begin
            v = first + 8 + j;
            chk($sformatf("%s_sum%0d", tag, j), sum_q[j], (3 * v - 12) % 256);
            chk($sformatf("%s_sum10_%0d", tag, j), sum10_q[j], 3 * v - 12);
            chk($sformatf("%s_fd%0d", tag, j), fd_q[j], (j == 7) ? 1 : 0);
            if (off + 8 + j < cap_q.size())
                chk($sformatf("%s_lat%0d", tag, j), cyc_q[j], cap_q[off + 8 + j]);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_po_sum", int'(po_sum), 0);
        chk("rst_po_flag", int'(po_flag), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        idle(2);

        // 1: spaced stream 1..16
        clear_q();
        send_seq(1, 16, 4);
        idle(3);
        check_frame("s1", 1, 0, 1);

        // 2: back-to-back stream 1..16
        clear_q();
        send_seq(1, 16, 0);
        idle(3);
        check_frame("s2", 1, 0, 1);
        for (int j = 1; j < 8 && j < cyc_q.size(); j++)
            chk($sformatf("s2_consec%0d", j), cyc_q[j] - cyc_q[j-1], 1);

        // 3: saturating bytes, SUM_W 8 and 10
        clear_q();
        for (int i = 0; i < 12; i++) drive(1'b1, 8'hFF);
        idle(25);
        chk("s3_count", sum_q.size(), 4);
        for (int j = 0; j < 4 && j < sum_q.size(); j++) begin
            chk($sformatf("s3_sum8_%0d", j), sum_q[j], 'hFD);
            chk($sformatf("s3_sum10_%0d", j), sum10_q[j], 'h2FD);
        end
        chk("s3_no_fd", fd_cnt, 0);

        // 4: partial frame then idle timeout
        clear_q();
        send_seq(100, 6, 0);
        idle(25);
        chk("s4_partial_silent", sum_q.size(), 0);
        send_seq(1, 16, 4);
        idle(3);
        check_frame("s4", 1, 6, 1);

        // 7: idle exactly IDLE_TIMEOUT cycles, next byte arrives in the timeout cycle
        clear_q();
        send_seq(1, 2, 0);
        idle(20);
        send_seq(3, 14, 0);
        idle(3);
        check_frame("s7", 1, 0, 1);

        // 5: reset mid-frame
        clear_q();
        send_seq(1, 10, 0);
        sys_rst = 1'b1;
        #1;
        chk("s5_rst_po_sum", int'(po_sum), 0);
        chk("s5_rst_po_flag", int'(po_flag), 0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        idle(2);
        clear_q();
        send_seq(1, 16, 4);
        idle(3);
        check_frame("s5", 1, 0, 1);

        // 6: two frames back-to-back
        clear_q();
        send_seq(1, 32, 0);
        idle(3);
        chk("s6_count", sum_q.size(), 16);
        chk("s6_fd_count", fd_cnt, 2);
        for (int j = 0; j < 8 && j + 8 < sum_q.size(); j++) begin
            chk($sformatf("s6_f1_sum%0d", j), sum_q[j], 15 + 3 * j);
            chk($sformatf("s6_f2_sum%0d", j), sum_q[j + 8], 63 + 3 * j);
            chk($sformatf("s6_f2_fd%0d", j), fd_q[j + 8], (j == 7) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
